// File: rtl/imm_gen_pipe_pkg.sv
// imm_gen_pipe_pkg: LEGv8 opcode patterns, immediate format codes and default widths.
package imm_gen_pipe_pkg;
  localparam int WORD_DEF = 64;
  localparam int INSTR_LEN_DEF = 32;
  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_SHAMT = 3'd1,
    IMM_ALU12 = 3'd2,
    IMM_D9    = 3'd3,
    IMM_CB19  = 3'd4,
    IMM_B26   = 3'd5,
    IMM_MOV16 = 3'd6,
    IMM_ZERO  = 3'd7
  } imm_kind_e;
  // op is instr[31:21]; MOV is the ORR-with-XZR register form
  function automatic imm_kind_e decode_kind(input logic [10:0] op);
    casez (op)
      11'b000101?????, 11'b100101?????: return IMM_B26;
      11'b01010100???, 11'b1011010????: return IMM_CB19;
      11'b1001000100?, 11'b1001001000?, 11'b1011001000?,
      11'b1101001000?, 11'b1101000100?, 11'b1111000100?: return IMM_ALU12;
      11'b11111000010, 11'b11111000000: return IMM_D9;
      11'b1101001101?: return IMM_SHAMT;
      11'b110100101??, 11'b111100101??: return IMM_MOV16;
      11'b10101010000: return IMM_ZERO;
      default: return IMM_NONE;
    endcase
  endfunction
endpackage

// File: rtl/imm_extract.sv
// imm_extract: combinational immediate extraction and format classification.
// Define IMM_SCALE_EN to scale branch offsets to bytes and shift MOVZ/MOVK by the hw field.
module imm_extract
  import imm_gen_pipe_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int INSTR_LEN = INSTR_LEN_DEF
) (
  input  logic [INSTR_LEN-1:0] instr,
  output logic [WORD-1:0]      imm,
  output imm_kind_e            kind,
  output logic                 unknown
);
  logic [WORD-1:0] cb, br, mv;
  assign kind = decode_kind(instr[31:21]);
  assign unknown = kind == IMM_NONE;
`ifdef IMM_SCALE_EN
  logic [5:0] hw_sh;
  assign hw_sh = {instr[22:21], 4'b0000};
  assign cb = WORD'($signed(instr[23:5])) << 2;
  assign br = WORD'($signed(instr[25:0])) << 2;
  assign mv = int'(hw_sh) >= WORD ? '0 : WORD'(instr[20:5]) << hw_sh;
`else
  assign cb = WORD'($signed(instr[23:5]));
  assign br = WORD'($signed(instr[25:0]));
  assign mv = WORD'(instr[20:5]);
`endif
  assign imm = kind == IMM_SHAMT ? WORD'($signed(instr[15:10])) :
               kind == IMM_ALU12 ? WORD'($signed(instr[21:10])) :
               kind == IMM_D9    ? WORD'($signed(instr[20:12])) :
               kind == IMM_CB19  ? cb :
               kind == IMM_B26   ? br :
               kind == IMM_MOV16 ? mv :
               kind == IMM_ZERO  ? '0 : WORD'(instr);
endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator with a one-entry skid buffer and unknown-opcode counter.
// Scaling of immediates follows IMM_SCALE_EN through imm_extract.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int WORD = WORD_DEF,
  parameter int INSTR_LEN = INSTR_LEN_DEF,
  parameter int TAG_W = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_LEN-1:0] in_instr,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD-1:0]      out_imm,
  output logic [2:0]           out_kind,
  output logic [TAG_W-1:0]     out_tag,
  output logic [15:0]          unk_cnt
);
  if (INSTR_LEN != 32 || WORD < 32) begin : g_bad_param
    $error("imm_gen_pipe: INSTR_LEN must be 32 and WORD at least 32");
  end
  logic [WORD-1:0] x_imm, skid_imm;
  imm_kind_e x_kind;
  logic x_unk, skid_full, accept, load;
  logic [2:0] skid_kind;
  logic [TAG_W-1:0] skid_tag;
  imm_extract #(.WORD(WORD), .INSTR_LEN(INSTR_LEN)) u_extract (
    .instr(in_instr), .imm(x_imm), .kind(x_kind), .unknown(x_unk)
  );
  // in_ready comes straight from a flop, so out_ready never reaches it combinationally
  assign in_ready = !skid_full;
  assign accept = in_valid & in_ready;
  assign load = !out_valid | out_ready;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_kind  <= IMM_NONE;
      out_tag   <= '0;
      skid_full <= 1'b0;
      skid_imm  <= '0;
      skid_kind <= IMM_NONE;
      skid_tag  <= '0;
      unk_cnt   <= '0;
    end else begin
      if (load) begin
        out_valid <= skid_full | accept;
        skid_full <= 1'b0;
        if (skid_full) begin
          out_imm  <= skid_imm;
          out_kind <= skid_kind;
          out_tag  <= skid_tag;
        end else if (accept) begin
          out_imm  <= x_imm;
          out_kind <= x_kind;
          out_tag  <= in_tag;
        end
      end else if (accept) begin
        skid_full <= 1'b1;
        skid_imm  <= x_imm;
        skid_kind <= x_kind;
        skid_tag  <= in_tag;
      end
      if (accept && x_unk && unk_cnt != 16'hFFFF) unk_cnt <= unk_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random stimulus against a queue-based reference of the immediate stage.
module tb_imm_gen_pipe;
  logic clk = 1'b0, reset_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_tag, out_imm, out_tag;
  logic [2:0] out_kind;
  logic [15:0] unk_cnt;
  int passed = 0, failed = 0, n_out = 0;
  logic [15:0] unk_m = '0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  kind;
    logic [63:0] tag;
  } exp_t;
  exp_t q[$];
  logic [10:0] ops [12] = '{11'b00010100000, 11'b10010100000, 11'b01010100000, 11'b10110101000,
                            11'b10010001000, 11'b11110001000, 11'b11111000010, 11'b11111000000,
                            11'b11010011011, 11'b11010010100, 11'b11110010100, 11'b10101010000};

  imm_gen_pipe dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_kind(out_kind), .out_tag(out_tag), .unk_cnt(unk_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] sx(input logic [63:0] v, input int n);
    return (v >= (64'd1 << (n - 1))) ? v - (64'd1 << n) : v;
  endfunction

  function automatic exp_t ref_imm(input logic [31:0] i, input logic [63:0] tag);
    exp_t e;
    logic [10:0] op;
    int sh;
    op = i[31:21];
    e.tag = tag;
    e.kind = 3'd0;
    e.imm = {32'd0, i};
    if (op ==? 11'b000101????? || op ==? 11'b100101?????) begin
      e.kind = 3'd5;
      e.imm = sx({38'd0, i[25:0]}, 26);
`ifdef IMM_SCALE_EN
      e.imm = e.imm * 4;
`endif
    end else if (op ==? 11'b01010100??? || op ==? 11'b10110100??? || op ==? 11'b10110101???) begin
      e.kind = 3'd4;
      e.imm = sx({45'd0, i[23:5]}, 19);
`ifdef IMM_SCALE_EN
      e.imm = e.imm * 4;
`endif
    end else if (op ==? 11'b1001000100? || op ==? 11'b1001001000? || op ==? 11'b1011001000? ||
                 op ==? 11'b1101001000? || op ==? 11'b1101000100? || op ==? 11'b1111000100?) begin
      e.kind = 3'd2;
      e.imm = sx({52'd0, i[21:10]}, 12);
    end else if (op == 11'b11111000010 || op == 11'b11111000000) begin
      e.kind = 3'd3;
      e.imm = sx({55'd0, i[20:12]}, 9);
    end else if (op ==? 11'b1101001101?) begin
      e.kind = 3'd1;
      e.imm = sx({58'd0, i[15:10]}, 6);
    end else if (op ==? 11'b110100101?? || op ==? 11'b111100101??) begin
      e.kind = 3'd6;
      e.imm = {48'd0, i[20:5]};
`ifdef IMM_SCALE_EN
      sh = 16 * int'(i[22:21]);
      e.imm = sh < 64 ? e.imm * (64'd1 << sh) : 64'd0;
`endif
    end else if (op == 11'b10101010000) begin
      e.kind = 3'd7;
      e.imm = 64'd0;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[31:21] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [63:0] t);
    in_valid = 1'b1;
    in_instr = i;
    in_tag = t;
  endtask

  // One clock: compare handshake and output against the model, then advance the model.
  task automatic tick();
    bit acc, drn;
    exp_t e;
    #1;
    chk("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    if (out_valid && q.size() > 0) begin
      chk("imm", out_imm, q[0].imm);
      chk("kind", {61'd0, out_kind}, {61'd0, q[0].kind});
      chk("tag", out_tag, q[0].tag);
    end
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn && q.size() > 0) begin
      void'(q.pop_front());
      n_out++;
    end
    if (acc) begin
      e = ref_imm(in_instr, in_tag);
      q.push_back(e);
      if (e.kind == 3'd0 && unk_m != 16'hFFFF) unk_m = unk_m + 16'd1;
    end
    @(posedge clk);
    #1;
    chk("unk_cnt", {48'd0, unk_cnt}, {48'd0, unk_m});
  endtask

  initial begin
    int base;
    logic [15:0] u0;
    reset_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_tag = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_imm", out_imm, 64'd0);
    chk("rst_out_kind", {61'd0, out_kind}, 64'd0);
    chk("rst_out_tag", out_tag, 64'd0);
    chk("rst_unk_cnt", {48'd0, unk_cnt}, 64'd0);
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(32'h913FFC41, 64'h1000);
    tick();
    in_valid = 1'b0;
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_kind", {61'd0, out_kind}, 64'd2);
    chk("addi_tag", out_tag, 64'h1000);
    tick();
    base = n_out;
    for (int k = 0; k < 8; k++) begin
      drive(32'hF85F8020, 64'h2000 + 64'(4 * k));
      tick();
      if (k == 0) begin
        chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur_kind", {61'd0, out_kind}, 64'd3);
      end
    end
    in_valid = 1'b0;
    tick();
    chk("ldur_stream_count", 64'(n_out - base), 64'd8);
    drive(32'h17FFFFFF, 64'h3000);
    tick();
    in_valid = 1'b0;
`ifdef IMM_SCALE_EN
    chk("b_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
`else
    chk("b_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    chk("b_kind", {61'd0, out_kind}, 64'd5);
    tick();
    drive(32'hD2B7DDE0, 64'h4000);
    tick();
    in_valid = 1'b0;
`ifdef IMM_SCALE_EN
    chk("movz_imm", out_imm, 64'h0000_0000_BEEF_0000);
`else
    chk("movz_imm", out_imm, 64'h0000_0000_0000_BEEF);
`endif
    chk("movz_kind", {61'd0, out_kind}, 64'd6);
    tick();
    out_ready = 1'b0;
    drive(32'h913FFC41, 64'h51);
    tick();
    drive(32'hF85F8020, 64'h52);
    tick();
    chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
    drive(32'h17FFFFFF, 64'h53);
    tick();
    chk("stall_tag_hold", out_tag, 64'h51);
    chk("stall_imm_hold", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    out_ready = 1'b1;
    tick();
    chk("drain_second", out_tag, 64'h52);
    tick();
    chk("drain_third", out_tag, 64'h53);
    in_valid = 1'b0;
    tick();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);
    u0 = unk_cnt;
    drive(32'h0000_0000, 64'h60);
    tick();
    in_valid = 1'b0;
    chk("unk_kind", {61'd0, out_kind}, 64'd0);
    chk("unk_imm", out_imm, 64'd0);
    chk("unk_inc", {48'd0, unk_cnt}, {48'd0, u0 + 16'd1});
    tick();
    repeat (400) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = rand_instr();
      in_tag = {$urandom, $urandom};
      out_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    drive(32'h0000_0000, 64'h70);
    tick();
    drive(32'h0000_0001, 64'h71);
    tick();
    in_valid = 1'b0;
    chk("full_in_ready", {63'd0, in_ready}, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst_unk_cnt", {48'd0, unk_cnt}, 64'd0);
    chk("arst_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    unk_m = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(32'h913FFC41, 64'h80);
    tick();
    in_valid = 1'b0;
    chk("post_rst_tag", out_tag, 64'h80);
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, passed + failed);
    $finish;
  end
endmodule
